ps2_key_event_ctrl: RTL and testbench

Sequencing controller between the PS/2 frame receiver (one byte per completed frame) and consumers such as the seven-segment, ASCII and console logic. It parses the scan-code byte stream (E0 extended prefix, F0 break prefix), suppresses typematic repeats of the held key and counts key presses. Decoded make/break events are queued in a small FIFO with a valid/ready interface so slow consumers never lose keys silently.

---
 rtl/ps2_key_event_ctrl.sv | 140 ++++++++++++++
 tb/tb_ps2_key_event_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan-code parser with typematic filter, press counter and event FIFO.
// Turns received bytes into make/break events behind a valid/ready queue.
module ps2_key_event_ctrl #(
    parameter int FIFO_DEPTH    = 8,
    parameter bit FILTER_REPEAT = 1'b1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    input  logic                          in_err,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [7:0]                    ev_code,
    output logic                          ev_ext,
    output logic                          ev_break,
    output logic [7:0]                    press_count,
    output logic                          held_valid,
    output logic [8:0]                    held_code,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          proto_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        GOT_E0,
        GOT_F0,
        GOT_E0F0
    } state_t;

    state_t state, state_nxt;

    logic       is_e0, is_f0, is_junk;
    logic       gen_make, gen_brk, gen_ext, perr;
    logic [8:0] key;
    logic       suppress, push, pop, full, accept;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [9:0]    head;

    assign is_e0   = (in_data == 8'hE0);
    assign is_f0   = (in_data == 8'hF0);
    assign is_junk = (in_data == 8'h00) || (in_data == 8'hFF);

    always_comb begin
        state_nxt = state;
        gen_make  = 1'b0;
        gen_brk   = 1'b0;
        gen_ext   = 1'b0;
        perr      = 1'b0;
        if (in_err) begin
            perr      = 1'b1;
            state_nxt = IDLE;
        end else if (in_valid) begin
            unique case (state)
                IDLE: begin
                    if (is_e0)        state_nxt = GOT_E0;
                    else if (is_f0)   state_nxt = GOT_F0;
                    else if (!is_junk) gen_make = 1'b1;
                end
                GOT_E0: begin
                    if (is_f0) begin
                        state_nxt = GOT_E0F0;
                    end else if (!is_e0) begin
                        state_nxt = IDLE;
                        gen_make  = !is_junk;
                        gen_ext   = 1'b1;
                    end
                end
                GOT_F0, GOT_E0F0: begin
                    state_nxt = IDLE;
                    gen_ext   = (state == GOT_E0F0);
                    // A second prefix after F0 is never a legal sequence
                    if (is_e0 || is_f0) perr = 1'b1;
                    else                gen_brk = !is_junk;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign key      = {gen_ext, in_data};
    assign suppress = FILTER_REPEAT && held_valid && (held_code == key);
    assign push     = gen_brk || (gen_make && !suppress);
    assign full     = (fifo_level == FULL_LVL);
    assign pop      = ev_valid && ev_ready;
    assign accept   = push && (!full || pop);

    assign head     = mem[rd_ptr];
    assign ev_valid = (fifo_level != '0);
    assign ev_code  = ev_valid ? head[7:0] : 8'h00;
    assign ev_ext   = ev_valid && head[8];
    assign ev_break = ev_valid && head[9];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            press_count <= 8'd0;
            held_valid  <= 1'b0;
            held_code   <= 9'd0;
            overflow    <= 1'b0;
            proto_err   <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
        end else begin
            state     <= state_nxt;
            proto_err <= perr;
            if (gen_make && !suppress) begin
                press_count <= press_count + 8'd1;
                held_code   <= key;
                held_valid  <= 1'b1;
            end
            if (gen_brk && held_valid && (held_code == key))
                held_valid <= 1'b0;
            if (push && !accept)
                overflow <= 1'b1;
            if (accept)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (accept && !pop)
                fifo_level <= fifo_level + LW'(1);
            else if (pop && !accept)
                fifo_level <= fifo_level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= {gen_brk, gen_ext, in_data};
    end

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Bench for ps2_key_event_ctrl: vector table, corner sequences and
// random traffic checked against a prefix-flag/queue reference model.
module tb_ps2_key_event_ctrl;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_err = 1'b0;
    logic       ev_ready = 1'b0;

    logic       ev_valid, ev_ext, ev_break, held_valid, overflow, proto_err;
    logic [7:0] ev_code, press_count;
    logic [8:0] held_code;
    logic [3:0] fifo_level;

    logic       ev_valid0, ev_ext0, ev_break0, held_valid0, overflow0, proto_err0;
    logic [7:0] ev_code0, press_count0;
    logic [8:0] held_code0;
    logic [3:0] fifo_level0;

    always #5 clk = ~clk;

    ps2_key_event_ctrl #(.FIFO_DEPTH(DEPTH), .FILTER_REPEAT(1'b1)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
        .in_err(in_err), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break),
        .press_count(press_count), .held_valid(held_valid),
        .held_code(held_code), .fifo_level(fifo_level),
        .overflow(overflow), .proto_err(proto_err)
    );

    ps2_key_event_ctrl #(.FIFO_DEPTH(DEPTH), .FILTER_REPEAT(1'b0)) dut0 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
        .in_err(in_err), .ev_valid(ev_valid0), .ev_ready(ev_ready),
        .ev_code(ev_code0), .ev_ext(ev_ext0), .ev_break(ev_break0),
        .press_count(press_count0), .held_valid(held_valid0),
        .held_code(held_code0), .fifo_level(fifo_level0),
        .overflow(overflow0), .proto_err(proto_err0)
    );

    int errors = 0;
    int checks = 0;

    // reference model: pending prefix flags plus a queue of {brk,ext,code}
    logic       m_pe, m_pb, m_hv, m_ovf, m_perr;
    logic [8:0] m_hc;
    logic [7:0] m_cnt;
    logic [9:0] mq[$];

    logic [7:0] popped[$];
    int         pops0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pe = 0; m_pb = 0; m_hv = 0; m_ovf = 0; m_perr = 0;
        m_hc = 0; m_cnt = 0;
        mq.delete();
    endtask

    task automatic model_step(input logic v, input logic [7:0] d,
                              input logic e, input logic r);
        logic       do_pop, do_push;
        logic [9:0] ev;
        logic [8:0] k;
        do_pop  = (mq.size() > 0) && r;
        do_push = 0;
        ev      = '0;
        m_perr  = 0;
        if (e) begin
            m_perr = 1; m_pe = 0; m_pb = 0;
        end else if (v) begin
            if (d == 8'hE0 || d == 8'hF0) begin
                if (m_pb) begin
                    m_perr = 1; m_pe = 0; m_pb = 0;
                end else if (d == 8'hE0) m_pe = 1;
                else m_pb = 1;
            end else if (d == 8'h00 || d == 8'hFF) begin
                m_pe = 0; m_pb = 0;
            end else begin
                k = {m_pe, d};
                if (m_pb) begin
                    do_push = 1;
                    ev = {1'b1, k};
                    if (m_hv && m_hc == k) m_hv = 0;
                end else if (!(m_hv && m_hc == k)) begin
                    do_push = 1;
                    ev = {1'b0, k};
                    m_cnt = m_cnt + 8'd1;
                    m_hv = 1;
                    m_hc = k;
                end
                m_pe = 0; m_pb = 0;
            end
        end
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            if (mq.size() < DEPTH) mq.push_back(ev);
            else m_ovf = 1;
        end
    endtask

    task automatic model_cmp();
        logic [9:0] h;
        h = (mq.size() > 0) ? mq[0] : 10'd0;
        chk("m_ev_valid", ev_valid, mq.size() > 0);
        chk("m_ev_code", ev_code, h[7:0]);
        chk("m_ev_ext", ev_ext, h[8]);
        chk("m_ev_break", ev_break, h[9]);
        chk("m_press_count", press_count, m_cnt);
        chk("m_held_valid", held_valid, m_hv);
        chk("m_held_code", held_code, m_hc);
        chk("m_fifo_level", fifo_level, mq.size());
        chk("m_overflow", overflow, m_ovf);
        chk("m_proto_err", proto_err, m_perr);
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic e,
                        input logic r, input logic rn = 1'b1);
        in_valid = v; in_data = d; in_err = e; ev_ready = r; resetn = rn;
        if (rn && ev_valid && r) popped.push_back(ev_code);
        if (rn && ev_valid0 && r) pops0++;
        @(posedge clk);
        if (!rn) model_reset();
        else model_step(v, d, e, r);
        #1;
        model_cmp();
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       e_valid;
        logic [7:0] e_code;
        logic       e_ext;
        logic       e_brk;
        logic       e_held;
        logic [8:0] e_hc;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [7:0] keys[9];
        logic [7:0] exp_drain[9];
        logic [7:0] c0, c1, b;
        int         n0, n1;
        logic       saw44;

        tbl[0]  = '{1'b1, 8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 9'h01C, 8'd1};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 9'h01C, 8'd1};
        tbl[2]  = '{1'b1, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 9'h01C, 8'd1};
        tbl[3]  = '{1'b1, 8'h1C, 1'b1, 8'h1C, 1'b0, 1'b1, 1'b0, 9'h000, 8'd1};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 9'h000, 8'd1};
        tbl[5]  = '{1'b1, 8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 9'h000, 8'd1};
        tbl[6]  = '{1'b1, 8'h75, 1'b1, 8'h75, 1'b1, 1'b0, 1'b1, 9'h175, 8'd2};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 9'h175, 8'd2};
        tbl[8]  = '{1'b1, 8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 9'h175, 8'd2};
        tbl[9]  = '{1'b1, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 9'h175, 8'd2};
        tbl[10] = '{1'b1, 8'h75, 1'b1, 8'h75, 1'b1, 1'b1, 1'b0, 9'h000, 8'd2};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 9'h000, 8'd2};

        keys = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
        exp_drain = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h4B};
        pops0 = 0;
        model_reset();

        // reset state
        step(1'b1, 8'h1C, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("rst_ev_valid", ev_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_count", press_count, 0);
        chk("rst_held", {held_valid, held_code}, 0);

        // basic and extended make/break vectors
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].v, tbl[i].d, 1'b0, 1'b1);
            chk($sformatf("vec%0d_valid", i), ev_valid, tbl[i].e_valid);
            chk($sformatf("vec%0d_code", i), ev_code, tbl[i].e_code);
            chk($sformatf("vec%0d_ext", i), ev_ext, tbl[i].e_ext);
            chk($sformatf("vec%0d_brk", i), ev_break, tbl[i].e_brk);
            chk($sformatf("vec%0d_held", i), held_valid, tbl[i].e_held);
            if (tbl[i].e_held)
                chk($sformatf("vec%0d_hcode", i), held_code, tbl[i].e_hc);
            chk($sformatf("vec%0d_cnt", i), press_count, tbl[i].e_cnt);
        end

        // typematic repeats, filtered and unfiltered instances
        c0 = press_count0; c1 = press_count;
        popped.delete(); pops0 = 0;
        step(1'b1, 8'h1C, 1'b0, 1'b1);
        step(1'b1, 8'h1C, 1'b0, 1'b1);
        step(1'b1, 8'h1C, 1'b0, 1'b1);
        step(1'b1, 8'hF0, 1'b0, 1'b1);
        step(1'b1, 8'h1C, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("typ_events_f1", popped.size(), 2);
        chk("typ_count_f1", press_count - c1, 1);
        chk("typ_events_f0", pops0, 4);
        chk("typ_count_f0", press_count0 - c0, 3);

        // overflow with a stalled consumer
        c1 = press_count;
        for (int i = 0; i < 9; i++) step(1'b1, keys[i], 1'b0, 1'b0);
        chk("ovf_level", fifo_level, 8);
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", press_count - c1, 9);
        popped.delete();
        step(1'b1, 8'h4B, 1'b0, 1'b1);
        chk("full_pushpop_level", fifo_level, 8);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("drain_count", popped.size(), 9);
        saw44 = 0;
        n0 = popped.size();
        n1 = (n0 < 9) ? n0 : 9;
        for (int i = 0; i < n1; i++) begin
            chk($sformatf("drain%0d", i), popped[i], exp_drain[i]);
            if (popped[i] == 8'h44) saw44 = 1;
        end
        chk("drain_no44", saw44, 0);
        chk("ovf_sticky", overflow, 1);

        // error recovery
        step(1'b1, 8'hF0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("err_pulse", proto_err, 1);
        step(1'b1, 8'h1C, 1'b0, 1'b1);
        chk("err_pulse_end", proto_err, 0);
        chk("err_ev_valid", ev_valid, 1);
        chk("err_ev_code", ev_code, 8'h1C);
        chk("err_ev_make", ev_break, 0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'hF0, 1'b0, 1'b1);
        step(1'b1, 8'hE0, 1'b0, 1'b1);
        chk("f0e0_perr", proto_err, 1);
        chk("f0e0_no_event", fifo_level, 0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // reset between prefix and key
        step(1'b1, 8'hE0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_level", fifo_level, 0);
        step(1'b1, 8'h1C, 1'b0, 1'b0);
        chk("mid_rst_code", ev_code, 8'h1C);
        chk("mid_rst_ext", ev_ext, 0);
        chk("mid_rst_cnt", press_count, 1);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 11))
                0, 1:  b = 8'hE0;
                2, 3:  b = 8'hF0;
                4:     b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
                5, 6:  b = 8'h1C;
                7:     b = 8'h75;
                8:     b = 8'h2C;
                9:     b = 8'h1D;
                default: b = 8'($urandom_range(1, 254));
            endcase
            if ($urandom_range(0, 19) == 0)
                step(1'b0, b, 1'b1, $urandom_range(0, 1) != 0);
            else
                step($urandom_range(0, 9) < 6, b, 1'b0,
                     $urandom_range(0, 9) < ((i / 150) % 2 == 0 ? 3 : 7));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
